logic_operand_sequencer: RTL and testbench
==========================================

# logic_operand_sequencer

Front-end sequencer for the logical unit. It collects two 4-bit operands and a 2-bit operation code from a shared 4-bit switch bank, one per `enter` press. It drives the packed 8-bit operand word and select lines into the logical unit, captures the unit's result in a register, and holds it for display until the next press. Between the board inputs and the logical unit it acts as the producing end; the logical unit is the consumer.

## Interface
Parameters:
- `OP_W`, 2: operation code width.
- `NIB_W`, 4: operand width. The packed word is 2*`NIB_W`.

Ports:
- `clk`, in, 1: system clock. This is the block's only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `sw`, in, 4: data switches. Carries an operand nibble, or an op code in `sw[1:0]`.
- `enter`, in, 1: level button, already synchronised and debounced. Each rising edge advances the sequence.
- `result_in`, in, 8: combinational result from the logical unit.
- `z`, out, 8: packed operand word. `z[7:4]` is x and `z[3:0]` is y.
- `select`, out, 2: operation code. 00 = AND, 01 = OR, 10 = XOR, 11 = NOT.
- `result`, out, 8: captured result.
- `done`, out, 1: high while `result` is valid.
- `state_led`, out, 3: encoding of the current state.

## Operation
- Press detection: `edge = enter & ~enter_q`, where `enter_q` is `enter` registered. A level held high produces exactly one edge.
- States, encoded on `state_led`:
  - `LOAD_X`=0
  - `LOAD_Y`=1
  - `LOAD_OP`=2
  - `EXEC`=3
  - `HOLD`=4
- Transitions:
  - `LOAD_X` + edge: `z[7:4]`←`sw`, go to `LOAD_Y`.
  - `LOAD_Y` + edge: `z[3:0]`←`sw`, go to `LOAD_OP`.
  - `LOAD_OP` + edge: `select`←`sw[1:0]`, go to `EXEC`. `sw[3:2]` is ignored.
  - `EXEC`: unconditional. Capture the result, go to `HOLD`.
  - `HOLD` + edge: `done`←0, `result`←0, go to `LOAD_X`. `z` and `select` keep their values until they are overwritten.
  - In any state without an edge, the state and all registers hold.
- Result capture width rule:
  - AND, OR, XOR: `result` = {4'b0, `result_in[3:0]`}. The logical unit drives only the low nibble for these ops, so the upper nibble of `result_in` is ignored.
  - NOT: `result` = `result_in[7:0]`, the full 8 bits.
- An edge arriving in `EXEC` is ignored. It is not queued.
- Unused state codes 5–7 go to `LOAD_X` on the next clock, with no other register change.

## Timing
- Every output is registered and there are no combinational paths from inputs to outputs. The one exception is that `result_in` is sampled only in `EXEC`.
- An edge seen at clock k updates state and registers at the edge ending cycle k.
- `EXEC` lasts exactly 1 cycle.
- `z` and `select` are stable for at least 1 full cycle before the capture edge. This gives the logical unit one clock period of combinational settling.
- Latency is 2 clocks from the third-press edge cycle to `done`=1.
- Reset values, applied at any state, mid-sequence included:
  - state = `LOAD_X`
  - `z` = 0
  - `select` = 0
  - `result` = 0
  - `done` = 0
  - `enter_q` = 1, so a button held through reset release generates no edge.
- `reset` has priority over `edge` when both occur in the same cycle.

## Structure
- The shared package holds:
  - the state enum and its `state_led` codes;
  - the op code constants `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NOT`;
  - `NIB_W`.
- The natural sub-module is `rise_detect` (`clk`, `reset`, `in` → `pulse`). It contains the `enter_q` register with reset value 1 and is reusable for other buttons.
- The FSM, operand registers and capture logic stay in the top module. The logical unit is instantiated by the parent, not inside this block.

## Test plan
- **Reset and XOR:** reset, then press with sw=0xA, then 0x6, then 0x2, with the logical unit model attached. Required: `z`=0xA6, `select`=2, `result`=0x0C, `done`=1, `state_led`=4, with `done` rising 2 clocks after the third edge.
- **NOT:** press with sw=0xF, then 0x0, then 0x3. Required: `z`=0xF0, `result`=0x0F, and the upper nibble is taken from `result_in`.
- **AND with garbage upper bits:** sequence 0xC, 0xA, 0x0, with the model driving `result_in[7:4]`=0xX or 0xF. Required: `result`=0x08, with the upper nibble forced to 0.
- **Held button:** hold `enter` high for 10 cycles in `LOAD_X`. Required: exactly one advance to `LOAD_Y`. Then press during `EXEC` by forcing an edge in that cycle. Required: no extra advance.
- **Reset mid-operation:** in `LOAD_OP` with `z`=0x5A, assert `reset` for 1 cycle while `enter` is rising. Required: every output is 0, `state_led`=0, and releasing reset with `enter` still high causes no advance.
- **Wrap:** in `HOLD`, press. Required: `done`=0, `result`=0, `state_led`=0, and `z` still 0xA6. A new sequence then overwrites `z` correctly.

Source files
------------

// File: rtl/logic_operand_sequencer_pkg.sv
// +-----------------------------------------------------------------------+
// | Package : logic_operand_sequencer_pkg                                 |
// | Shared state encoding, op codes and widths for the operand sequencer. |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

package logic_operand_sequencer_pkg;

   localparam int NIB_W = 4;
   localparam int OP_W  = 2;

   // Values double as the state_led codes.
   typedef enum logic [2:0] {
      LOAD_X  = 3'd0,
      LOAD_Y  = 3'd1,
      LOAD_OP = 3'd2,
      EXEC    = 3'd3,
      HOLD    = 3'd4
   } state_t;

   localparam logic [OP_W-1:0] OP_AND = 2'b00;
   localparam logic [OP_W-1:0] OP_OR  = 2'b01;
   localparam logic [OP_W-1:0] OP_XOR = 2'b10;
   localparam logic [OP_W-1:0] OP_NOT = 2'b11;

endpackage

`default_nettype wire

// File: rtl/logic_operand_sequencer_if.sv
// +-----------------------------------------------------------------------+
// | Interface : logic_operand_sequencer_if                                |
// | Board inputs, logical-unit link and display outputs of the sequencer. |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

interface logic_operand_sequencer_if #(
   parameter int NIB_W = 4,
   parameter int OP_W  = 2
);
   logic [NIB_W-1:0]   sw;
   logic               enter;
   logic [2*NIB_W-1:0] result_in;
   logic [2*NIB_W-1:0] z;
   logic [OP_W-1:0]    select;
   logic [2*NIB_W-1:0] result;
   logic               done;
   logic [2:0]         state_led;

   // master: the sequencer itself; slave: board plus logical unit.
   modport master (
      input  sw, enter, result_in,
      output z, select, result, done, state_led
   );

   modport slave (
      output sw, enter, result_in,
      input  z, select, result, done, state_led
   );
endinterface

`default_nettype wire

// File: rtl/logic_operand_sequencer_rise_detect.sv
// +-----------------------------------------------------------------------+
// | Module : rise_detect                                                  |
// | One-cycle pulse on each rising edge of a synchronised level input.    |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

module rise_detect (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic in,
   output logic      pulse
);
   logic in_q;

   // Resets high so a level held through reset release is not a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_q <= 1'b1;
      end else begin
         in_q <= in;
      end
   end

   assign pulse = in & ~in_q;
endmodule

`default_nettype wire

// File: rtl/logic_operand_sequencer.sv
// +-----------------------------------------------------------------------+
// | Module : logic_operand_sequencer                                      |
// | Collects x, y and op from the switch bank and captures the result.    |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

module logic_operand_sequencer
   import logic_operand_sequencer_pkg::*;
#(
   parameter int OP_W  = 2,
   parameter int NIB_W = logic_operand_sequencer_pkg::NIB_W
) (
   input  wire logic                 clk,
   input  wire logic                 reset,
   logic_operand_sequencer_if.master bus
);
   logic               w_press;
   state_t             state_q, state_d;
   logic [2*NIB_W-1:0] z_q, z_d;
   logic [OP_W-1:0]    sel_q, sel_d;
   logic [2*NIB_W-1:0] res_q, res_d;
   logic               done_q, done_d;

   rise_detect u_enter_edge (
      .clk   (clk),
      .reset (reset),
      .in    (bus.enter),
      .pulse (w_press)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD_X;
         z_q     <= '0;
         sel_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         sel_q   <= sel_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      sel_d   = sel_q;
      res_d   = res_q;
      done_d  = done_q;
      case (state_q)
         LOAD_X: if (w_press) begin
            z_d[2*NIB_W-1:NIB_W] = bus.sw;
            state_d              = LOAD_Y;
         end
         LOAD_Y: if (w_press) begin
            z_d[NIB_W-1:0] = bus.sw;
            state_d        = LOAD_OP;
         end
         LOAD_OP: if (w_press) begin
            sel_d   = bus.sw[OP_W-1:0];
            state_d = EXEC;
         end
         EXEC: begin
            // Only NOT drives the upper nibble; for the others it is don't-care.
            if (sel_q == OP_NOT) begin
               res_d = bus.result_in;
            end else begin
               res_d = {{NIB_W{1'b0}}, bus.result_in[NIB_W-1:0]};
            end
            done_d  = 1'b1;
            state_d = HOLD;
         end
         HOLD: if (w_press) begin
            res_d   = '0;
            done_d  = 1'b0;
            state_d = LOAD_X;
         end
         default: state_d = LOAD_X;
      endcase
   end

   assign bus.z         = z_q;
   assign bus.select    = sel_q;
   assign bus.result    = res_q;
   assign bus.done      = done_q;
   assign bus.state_led = state_q;
endmodule

`default_nettype wire

// File: tb/tb_logic_operand_sequencer.sv
// +-----------------------------------------------------------------------+
// | Module : tb_logic_operand_sequencer                                   |
// | Self-checking bench with a logical-unit model and reference results.  |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_logic_operand_sequencer;
   logic       clk;
   logic       reset;
   logic [3:0] garb;
   int         errors;
   int         checks;

   logic_operand_sequencer_if bus ();

   logic_operand_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Logical unit: low-nibble ops leave garbage in the upper nibble.
   always_comb begin
      bus.result_in = 8'h00;
      case (bus.select)
         2'b00:   bus.result_in = {garb, bus.z[7:4] & bus.z[3:0]};
         2'b01:   bus.result_in = {garb, bus.z[7:4] | bus.z[3:0]};
         2'b10:   bus.result_in = {garb, bus.z[7:4] ^ bus.z[3:0]};
         default: bus.result_in = ~bus.z;
      endcase
   end

   // Reference: the value the display must show for operands x, y and op.
   function automatic logic [7:0] ref_result(input logic [3:0] x, input logic [3:0] y,
                                             input logic [1:0] op);
      case (op)
         2'b00:   return {4'h0, x & y};
         2'b01:   return {4'h0, x | y};
         2'b10:   return {4'h0, x ^ y};
         default: return ~{x, y};
      endcase
   endfunction

   task automatic press(input logic [3:0] v);
      @(negedge clk);
      bus.sw    = v;
      bus.enter = 1'b1;
      @(negedge clk);
      bus.enter = 1'b0;
   endtask

   task automatic test_reset;
      reset     = 1'b1;
      bus.enter = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.z !== 8'h00) begin errors++; $display("FAIL reset_z: got %h want 00", bus.z); end
      checks++; if (bus.select !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", bus.select); end
      checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL reset_res: got %h want 00", bus.result); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.state_led !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state_led); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.state_led !== 3'd0) begin errors++; $display("FAIL reset_held_enter: got %0d want 0", bus.state_led); end
      bus.enter = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_xor;
      garb = 4'(($urandom));
      press(4'hA); press(4'h6); press(4'h2);
      checks++; if (bus.state_led !== 3'd3 || bus.done !== 1'b0) begin
         errors++; $display("FAIL xor_exec: got state %0d done %b want 3 0", bus.state_led, bus.done); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL xor_done_latency: got %b want 1", bus.done); end
      checks++; if (bus.z !== 8'hA6) begin errors++; $display("FAIL xor_z: got %h want a6", bus.z); end
      checks++; if (bus.select !== 2'd2) begin errors++; $display("FAIL xor_sel: got %0d want 2", bus.select); end
      checks++; if (bus.result !== 8'h0C) begin errors++; $display("FAIL xor_res: got %h want 0c", bus.result); end
      checks++; if (bus.state_led !== 3'd4) begin errors++; $display("FAIL xor_state: got %0d want 4", bus.state_led); end
   endtask

   task automatic test_wrap;
      press(4'h3);
      checks++; if (bus.done !== 1'b0 || bus.result !== 8'h00) begin
         errors++; $display("FAIL wrap_clear: got done %b res %h want 0 00", bus.done, bus.result); end
      checks++; if (bus.state_led !== 3'd0) begin errors++; $display("FAIL wrap_state: got %0d want 0", bus.state_led); end
      checks++; if (bus.z !== 8'hA6 || bus.select !== 2'd2) begin
         errors++; $display("FAIL wrap_keep: got z %h sel %0d want a6 2", bus.z, bus.select); end
      press(4'h5);
      checks++; if (bus.z !== 8'h56 || bus.state_led !== 3'd1) begin
         errors++; $display("FAIL wrap_x: got z %h state %0d want 56 1", bus.z, bus.state_led); end
      press(4'h9);
      checks++; if (bus.z !== 8'h59) begin errors++; $display("FAIL wrap_y: got %h want 59", bus.z); end
      press(4'h1);
      @(negedge clk);
      checks++; if (bus.result !== 8'h0D || bus.select !== 2'd1) begin
         errors++; $display("FAIL wrap_or: got res %h sel %0d want 0d 1", bus.result, bus.select); end
      press(4'h0);
   endtask

   task automatic test_not;
      garb = 4'(($urandom));
      press(4'hF); press(4'h0); press(4'h3);
      @(negedge clk);
      checks++; if (bus.z !== 8'hF0 || bus.result !== 8'h0F) begin
         errors++; $display("FAIL not_f0: got z %h res %h want f0 0f", bus.z, bus.result); end
      press(4'h0);
      press(4'h3); press(4'hC); press(4'hF);
      @(negedge clk);
      checks++; if (bus.result !== 8'hC3 || bus.select !== 2'd3) begin
         errors++; $display("FAIL not_upper: got res %h sel %0d want c3 3", bus.result, bus.select); end
      press(4'h0);
   endtask

   task automatic test_and_garbage;
      garb = 4'hF;
      press(4'hC); press(4'hA); press(4'h0);
      @(negedge clk);
      checks++; if (bus.result !== 8'h08 || bus.done !== 1'b1) begin
         errors++; $display("FAIL and_garbage: got res %h done %b want 08 1", bus.result, bus.done); end
      press(4'h0);
   endtask

   task automatic test_held;
      garb = 4'h0;
      @(negedge clk);
      bus.sw    = 4'h8;
      bus.enter = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (bus.state_led !== 3'd1 || bus.z[7:4] !== 4'h8) begin
         errors++; $display("FAIL held_once: got state %0d x %h want 1 8", bus.state_led, bus.z[7:4]); end
      bus.enter = 1'b0;
      press(4'h3);
      checks++; if (bus.state_led !== 3'd2) begin errors++; $display("FAIL held_loadop: got %0d want 2", bus.state_led); end
      press(4'h1);
      force dut.w_press = 1'b1;
      @(negedge clk);
      release dut.w_press;
      checks++; if (bus.state_led !== 3'd4 || bus.result !== 8'h0B) begin
         errors++; $display("FAIL exec_edge_ignored: got state %0d res %h want 4 0b", bus.state_led, bus.result); end
      @(negedge clk);
      checks++; if (bus.state_led !== 3'd4) begin errors++; $display("FAIL exec_edge_queued: got %0d want 4", bus.state_led); end
      press(4'h0);
   endtask

   task automatic test_reset_mid;
      press(4'h5); press(4'hA);
      checks++; if (bus.state_led !== 3'd2 || bus.z !== 8'h5A) begin
         errors++; $display("FAIL mid_setup: got state %0d z %h want 2 5a", bus.state_led, bus.z); end
      reset     = 1'b1;
      bus.enter = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (bus.z !== 8'h00 || bus.select !== 2'd0 || bus.result !== 8'h00 ||
                    bus.done !== 1'b0 || bus.state_led !== 3'd0) begin
         errors++; $display("FAIL mid_reset: got z %h sel %0d res %h done %b state %0d want all 0",
                            bus.z, bus.select, bus.result, bus.done, bus.state_led); end
      repeat (3) @(negedge clk);
      checks++; if (bus.state_led !== 3'd0 || bus.z !== 8'h00) begin
         errors++; $display("FAIL mid_release: got state %0d z %h want 0 00", bus.state_led, bus.z); end
      bus.enter = 1'b0;
   endtask

   task automatic test_random;
      logic [3:0] x, y, opsw;
      logic [7:0] want;
      for (int i = 0; i < 25; i++) begin
         x    = 4'($urandom);
         y    = 4'($urandom);
         opsw = 4'($urandom);
         garb = 4'($urandom);
         want = ref_result(x, y, opsw[1:0]);
         press(x); press(y); press(opsw);
         checks++; if (bus.state_led !== 3'd3) begin errors++; $display("FAIL rand_exec[%0d]: got %0d want 3", i, bus.state_led); end
         @(negedge clk);
         checks++; if (bus.z !== {x, y} || bus.select !== opsw[1:0]) begin
            errors++; $display("FAIL rand_ops[%0d]: got z %h sel %0d want %h %0d", i, bus.z, bus.select, {x, y}, opsw[1:0]); end
         checks++; if (bus.result !== want || bus.done !== 1'b1) begin
            errors++; $display("FAIL rand_res[%0d]: got res %h done %b want %h 1", i, bus.result, bus.done, want); end
         press(4'($urandom));
         checks++; if (bus.state_led !== 3'd0 || bus.result !== 8'h00 || bus.done !== 1'b0) begin
            errors++; $display("FAIL rand_wrap[%0d]: got state %0d res %h done %b want 0 00 0", i, bus.state_led, bus.result, bus.done); end
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      garb      = 4'h0;
      reset     = 1'b1;
      bus.sw    = 4'h0;
      bus.enter = 1'b0;
      @(negedge clk);
      test_reset();
      test_xor();
      test_wrap();
      test_not();
      test_and_garbage();
      test_held();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

`default_nettype wire
